// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  localparam int unsigned ARB_N_REQ = 4;
  localparam int unsigned IDXW      = $clog2(ARB_N_REQ);
  localparam int unsigned ONEHOT_W  = 32;

  typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;

  // Wide one-hot; callers truncate to their requester count.
  function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned idx);
    onehot = ONEHOT_W'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotate-priority picker: first requester after `last`, wrapping, `last` itself scanned last.
module rr_picker #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int unsigned IW = $clog2(N_REQ);

  always_comb begin : scan
    int unsigned pos;
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    // walk from farthest to nearest so the nearest requester overwrites
    for (int k = int'(N_REQ); k >= 1; k--) begin
      pos = (32'(last) + 32'(k)) % N_REQ;
      if (req[pos[IW-1:0]]) begin
        valid = 1'b1;
        idx   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// Shares one FIFO write port between N_REQ producers with round-robin, burst-bounded grants.
module fifo_rr_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       gnt,
  input  logic                   fifo_full,
  output logic                   fifo_write,
  output logic [WIDTH-1:0]       fifo_data,
  output logic [N_REQ-1:0]       xfer
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(BURST) + 1;
  localparam logic [CW-1:0] BCNT_LAST = CW'(BURST - 1);

  arb_state_t       state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    last_q, last_d;
  logic [CW-1:0]    bcnt_q, bcnt_d;
  logic [N_REQ-1:0] gnt_d;
  logic [N_REQ-1:0] owner_oh;
  logic [IW-1:0]    pick_last;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;
  logic             owning;
  logic             wr;
  logic             release_c;
  logic             others;

  // In OWN the only re-pick happens on release, where last becomes the owner.
  assign pick_last = (state_q == ARB_OWN) ? owner_q : last_q;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req   (req),
    .last  (pick_last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Write path; reset suppresses the strobe so no word is written mid-reset.
  always_comb begin
    owner_oh   = N_REQ'(onehot(32'(owner_q)));
    owning     = (state_q == ARB_OWN) && !rst_n;
    wr         = owning && req[owner_q] && !fifo_full;
    fifo_write = wr;
    fifo_data  = owning ? req_data[owner_q*WIDTH +: WIDTH] : '0;
    xfer       = wr ? owner_oh : '0;
    release_c  = (state_q == ARB_OWN) && (!req[owner_q] || (wr && (bcnt_q == BCNT_LAST)));
    others     = |(req & ~owner_oh);
  end

  // Next-state and grant logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_OWN;
          owner_d = pick_idx;
          bcnt_d  = '0;
        end
      end
      ARB_OWN: begin
        if (wr) bcnt_d = bcnt_q + CW'(1);
        if (release_c) begin
          last_d = owner_q;
          bcnt_d = '0;
          if (others && pick_valid) owner_d = pick_idx;
          else                      state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    gnt_d = (state_d == ARB_OWN) ? N_REQ'(onehot(32'(owner_d))) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      last_q  <= IW'(N_REQ - 1);
      bcnt_q  <= '0;
      gnt     <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
      gnt     <= gnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Directed scenarios plus a randomized run checked against a round-robin reference model.
module tb_fifo_rr_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int B = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           fifo_full;
  logic           fifo_write;
  logic [W-1:0]   fifo_data;
  logic [N-1:0]   xfer;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_owner;
  int m_cnt;
  int m_last;

  always #5 clk = ~clk;

  fifo_rr_write_arbiter #(.N_REQ(N), .WIDTH(W), .BURST(B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .fifo_full  (fifo_full),
    .fifo_write (fifo_write),
    .fifo_data  (fifo_data),
    .xfer       (xfer)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b1;
    req       = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    tick();
    tick();
    rst_n     = 1'b0;
    m_owner   = -1;
    m_cnt     = 0;
    m_last    = N - 1;
  endtask

  function automatic int scan(input int from, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++)
      if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  // Advance the reference model by one clock using the currently driven inputs.
  task automatic model_update(input logic wrote);
    logic [N-1:0] mask;
    if (m_owner < 0) begin
      if (req != '0) begin
        m_owner = scan(m_last, req);
        m_cnt   = 0;
      end
    end else begin
      if (wrote) m_cnt++;
      if (!req[m_owner] || (wrote && m_cnt == B)) begin
        m_last = m_owner;
        mask = '0;
        mask[m_owner] = 1'b1;
        if ((req & ~mask) != '0) m_owner = scan(m_last, req);
        else                     m_owner = -1;
        m_cnt = 0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    req       = 4'b1111;
    req_data  = 32'hDEADBEEF;
    fifo_full = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if (fifo_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", fifo_write); end
    checks++; if (xfer !== 4'b0000) begin errors++; $display("FAIL reset_xfer: got %b want 0000", xfer); end
    checks++; if (fifo_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", fifo_data); end
    tick();
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    req_data[7:0] = 8'hA5;
    @(negedge clk);
    checks++; if (gnt !== 4'b0000 || fifo_write !== 1'b0) begin errors++; $display("FAIL single_idle: got gnt=%b wr=%b want 0000/0", gnt, fifo_write); end
    tick();
    for (int c = 0; c < B; c++) begin
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt c=%0d: got %b want 0001", c, gnt); end
      checks++; if (fifo_write !== 1'b1 || fifo_data !== 8'hA5) begin errors++; $display("FAIL single_write c=%0d: got wr=%b data=%h want 1/a5", c, fifo_write, fifo_data); end
      checks++; if (xfer !== 4'b0001) begin errors++; $display("FAIL single_xfer c=%0d: got %b want 0001", c, xfer); end
      tick();
    end
    @(negedge clk);
    checks++; if (gnt !== 4'b0000 || fifo_write !== 1'b0) begin errors++; $display("FAIL single_release: got gnt=%b wr=%b want 0000/0", gnt, fifo_write); end
    tick();
    @(negedge clk);
    checks++; if (gnt !== 4'b0001 || fifo_write !== 1'b1) begin errors++; $display("FAIL single_regrant: got gnt=%b wr=%b want 0001/1", gnt, fifo_write); end
    tick();
    req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_all_req();
    logic [N-1:0] eg;
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'(8'h11 * (i + 1));
    req = 4'b1111;
    tick();
    for (int k = 0; k <= N * B; k++) begin
      @(negedge clk);
      eg = '0;
      eg[(k / B) % N] = 1'b1;
      checks++; if (gnt !== eg) begin errors++; $display("FAIL all_gnt k=%0d: got %b want %b", k, gnt, eg); end
      checks++; if (fifo_write !== 1'b1 || fifo_data !== 8'(8'h11 * ((k / B) % N + 1))) begin
        errors++; $display("FAIL all_write k=%0d: got wr=%b data=%h want 1/%h", k, fifo_write, fifo_data, 8'(8'h11 * ((k / B) % N + 1)));
      end
      tick();
    end
    req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_stall();
    do_reset();
    req_data[2*W +: W] = 8'hC2;
    req_data[3*W +: W] = 8'hD3;
    req = 4'b1100;
    tick();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (gnt !== 4'b0100 || fifo_write !== 1'b1 || fifo_data !== 8'hC2) begin
        errors++; $display("FAIL stall_pre c=%0d: got gnt=%b wr=%b data=%h want 0100/1/c2", c, gnt, fifo_write, fifo_data);
      end
      tick();
    end
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (gnt !== 4'b0100 || fifo_write !== 1'b0 || xfer !== 4'b0000) begin
        errors++; $display("FAIL stall_hold c=%0d: got gnt=%b wr=%b xfer=%b want 0100/0/0000", c, gnt, fifo_write, xfer);
      end
      tick();
    end
    fifo_full = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (gnt !== 4'b0100 || fifo_write !== 1'b1) begin
        errors++; $display("FAIL stall_post c=%0d: got gnt=%b wr=%b want 0100/1", c, gnt, fifo_write);
      end
      tick();
    end
    @(negedge clk);
    checks++; if (gnt !== 4'b1000 || fifo_write !== 1'b1 || fifo_data !== 8'hD3) begin
      errors++; $display("FAIL stall_rotate: got gnt=%b wr=%b data=%h want 1000/1/d3", gnt, fifo_write, fifo_data);
    end
    tick();
    req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_drop();
    do_reset();
    req_data[1*W +: W] = 8'h5A;
    req_data[2*W +: W] = 8'h6B;
    req = 4'b0110;
    tick();
    @(negedge clk);
    checks++; if (gnt !== 4'b0010 || fifo_write !== 1'b1 || fifo_data !== 8'h5A) begin
      errors++; $display("FAIL drop_first: got gnt=%b wr=%b data=%h want 0010/1/5a", gnt, fifo_write, fifo_data);
    end
    tick();
    req = 4'b0100;
    @(negedge clk);
    checks++; if (fifo_write !== 1'b0 || xfer !== 4'b0000) begin
      errors++; $display("FAIL drop_nowrite: got wr=%b xfer=%b want 0/0000", fifo_write, xfer);
    end
    tick();
    @(negedge clk);
    checks++; if (gnt !== 4'b0100 || fifo_write !== 1'b1 || fifo_data !== 8'h6B) begin
      errors++; $display("FAIL drop_handover: got gnt=%b wr=%b data=%h want 0100/1/6b", gnt, fifo_write, fifo_data);
    end
    tick();
    req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b1111;
    tick();
    for (int c = 0; c < B + 1; c++) tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (gnt !== 4'b0000 || fifo_write !== 1'b0 || xfer !== 4'b0000) begin
      errors++; $display("FAIL midrst_clear: got gnt=%b wr=%b xfer=%b want 0000/0/0000", gnt, fifo_write, xfer);
    end
    rst_n = 1'b0;
    req   = 4'b1001;
    tick();
    @(negedge clk);
    checks++; if (gnt !== 4'b0001 || fifo_write !== 1'b1) begin
      errors++; $display("FAIL midrst_first: got gnt=%b wr=%b want 0001/1", gnt, fifo_write);
    end
    tick();
    req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_random();
    logic [W-1:0]   mem [N][16];
    int             head [N];
    int             cnt  [N];
    int             waitc [N];
    logic [N-1:0]   eg;
    logic           ew;
    int             len;
    do_reset();
    for (int i = 0; i < N; i++) begin head[i] = 0; cnt[i] = 0; waitc[i] = 0; end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (cnt[i] == 0 && $urandom_range(0, 5) == 0) begin
          len = int'($urandom_range(1, 6));
          for (int j = 0; j < len; j++) mem[i][(head[i] + cnt[i] + j) % 16] = 8'($urandom);
          cnt[i] += len;
        end
        req[i] = (cnt[i] != 0);
        req_data[i*W +: W] = mem[i][head[i]];
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      ew = (m_owner >= 0) && req[m_owner] && !fifo_full;
      checks++; if (gnt !== eg) begin errors++; $display("FAIL rnd_gnt cyc=%0d: got %b want %b", cyc, gnt, eg); end
      checks++; if (fifo_write !== ew) begin errors++; $display("FAIL rnd_write cyc=%0d: got %b want %b full=%b", cyc, fifo_write, ew, fifo_full); end
      checks++; if (xfer !== (ew ? eg : 4'b0000)) begin errors++; $display("FAIL rnd_xfer cyc=%0d: got %b want %b", cyc, xfer, ew ? eg : 4'b0000); end
      if (ew) begin
        checks++; if (fifo_data !== mem[m_owner][head[m_owner]]) begin
          errors++; $display("FAIL rnd_data cyc=%0d src=%0d: got %h want %h", cyc, m_owner, fifo_data, mem[m_owner][head[m_owner]]);
        end
        checks++; if (waitc[m_owner] > (N - 1) * B) begin
          errors++; $display("FAIL rnd_fair cyc=%0d src=%0d: got wait %0d want <= %0d", cyc, m_owner, waitc[m_owner], (N - 1) * B);
        end
        for (int i = 0; i < N; i++)
          if (i != m_owner && req[i]) waitc[i]++;
        waitc[m_owner] = 0;
        head[m_owner] = (head[m_owner] + 1) % 16;
        cnt[m_owner]--;
      end
      for (int i = 0; i < N; i++) if (!req[i]) waitc[i] = 0;
      model_update(ew);
      tick();
    end
    req = '0;
    fifo_full = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    rst_n     = 1'b1;
    req       = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    m_owner   = -1;
    m_cnt     = 0;
    m_last    = N - 1;
    test_reset();
    test_single();
    test_all_req();
    test_stall();
    test_drop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
